// File: rtl/tdm_demux_rx.sv
// tdm_demux_rx: receive-side TDM de-interleaver.
// Locks onto frame_sync (channel-0 marker) and collects CH_N slots per frame.
// Each completed frame is presented on dout, together with a one-cycle dout_valid pulse.
// Optional feature macro: FRAME_ERR_EN adds a frame_err pulse on premature sync.
module tdm_demux_rx #(
  parameter int CH_N   = 2,
  parameter int DATA_W = 1,
  localparam int CNT_W = $clog2(CH_N)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      din,
  input  logic                   din_valid,
  input  logic                   frame_sync,
  output logic [CH_N*DATA_W-1:0] dout,
  output logic                   dout_valid,
  output logic [CNT_W-1:0]       chan,
  output logic                   locked
`ifdef FRAME_ERR_EN
  ,
  output logic                   frame_err
`endif
);

  typedef enum logic {
    HUNT = 1'b0,
    LOCK = 1'b1
  } state_t;

  state_t                  state_reg;
  logic [DATA_W-1:0]       slot_reg [CH_N];
  logic                    premature;
  logic                    wr_en;
  logic                    last_slot;
  logic [CNT_W-1:0]        wr_idx;
  logic [CH_N*DATA_W-1:0]  frame_next;

  // Classify the current sample: which slot it lands in and whether it closes a frame.
  always_comb begin
    premature = (state_reg == LOCK) && frame_sync && (chan != '0);
    // In HUNT only a sync sample is kept; in LOCK every accepted sample is kept.
    wr_en     = din_valid && ((state_reg == LOCK) || frame_sync);
    // A sync sample in HUNT or a premature sync restarts the frame at slot 0.
    wr_idx    = ((state_reg == HUNT) || premature) ? '0 : chan;
    last_slot = (state_reg == LOCK) && !premature && (chan == CNT_W'(CH_N - 1));
  end

  // Partial-frame buffer: one register per slot, plus the assembled frame.
  // The last slot bypasses the buffer so the frame is complete on the accepting edge.
  generate
    for (genvar gi = 0; gi < CH_N; gi++) begin : g_slot
      // Store the accepted sample into this slot when it is the addressed one.
      always_ff @(posedge clk) begin
        if (rst) begin
          slot_reg[gi] <= '0;
        end else if (wr_en && (wr_idx == CNT_W'(gi))) begin
          slot_reg[gi] <= din;
        end
      end

      if (gi == CH_N - 1) begin : g_last
        assign frame_next[gi*DATA_W +: DATA_W] = din;
      end else begin : g_mid
        assign frame_next[gi*DATA_W +: DATA_W] = slot_reg[gi];
      end
    end
  endgenerate

  // Lock FSM with slot counter and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= HUNT;
      chan       <= '0;
      locked     <= 1'b0;
      dout       <= '0;
      dout_valid <= 1'b0;
`ifdef FRAME_ERR_EN
      frame_err  <= 1'b0;
`endif
    end else begin
      dout_valid <= 1'b0;
`ifdef FRAME_ERR_EN
      frame_err  <= 1'b0;
`endif
      if (din_valid) begin
        case (state_reg)
          HUNT: begin
            // Samples before the first sync are dropped.
            if (frame_sync) begin
              state_reg <= LOCK;
              locked    <= 1'b1;
              chan      <= CNT_W'(1);
            end
          end
          LOCK: begin
            if (premature) begin
              // Abandon the partial frame; this sample already went to slot 0.
              chan <= CNT_W'(1);
`ifdef FRAME_ERR_EN
              frame_err <= 1'b1;
`endif
            end else if (last_slot) begin
              chan       <= '0;
              dout       <= frame_next;
              dout_valid <= 1'b1;
            end else begin
              chan <= chan + CNT_W'(1);
            end
          end
          default: begin
            state_reg <= HUNT;
            locked    <= 1'b0;
            chan      <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdm_demux_rx.sv
// tb_tdm_demux_rx: three instances (CH_N/DATA_W = 2/1, 4/8, 3/4) share one
// stimulus stream; din is sliced to each instance's width.
// A frame-level reference model predicts every output after every clock.
module tb_tdm_demux_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       din_valid = 1'b0;
  logic       frame_sync = 1'b0;
  logic [7:0] din = '0;

  logic [1:0]  dout_a;  logic valid_a; logic       chan_a; logic locked_a;
  logic [31:0] dout_b;  logic valid_b; logic [1:0] chan_b; logic locked_b;
  logic [11:0] dout_c;  logic valid_c; logic [1:0] chan_c; logic locked_c;
`ifdef FRAME_ERR_EN
  logic err_a, err_b, err_c;
`endif

  tdm_demux_rx #(.CH_N(2), .DATA_W(1)) u_a (
    .clk(clk), .rst(rst), .din(din[0:0]), .din_valid(din_valid), .frame_sync(frame_sync),
    .dout(dout_a), .dout_valid(valid_a), .chan(chan_a), .locked(locked_a)
`ifdef FRAME_ERR_EN
    , .frame_err(err_a)
`endif
  );

  tdm_demux_rx #(.CH_N(4), .DATA_W(8)) u_b (
    .clk(clk), .rst(rst), .din(din[7:0]), .din_valid(din_valid), .frame_sync(frame_sync),
    .dout(dout_b), .dout_valid(valid_b), .chan(chan_b), .locked(locked_b)
`ifdef FRAME_ERR_EN
    , .frame_err(err_b)
`endif
  );

  tdm_demux_rx #(.CH_N(3), .DATA_W(4)) u_c (
    .clk(clk), .rst(rst), .din(din[3:0]), .din_valid(din_valid), .frame_sync(frame_sync),
    .dout(dout_c), .dout_valid(valid_c), .chan(chan_c), .locked(locked_c)
`ifdef FRAME_ERR_EN
    , .frame_err(err_c)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  // ---------------- reference model (frame level) ----------------
  int          nch [3] = '{2, 4, 3};
  int          wid [3] = '{1, 8, 4};
  bit          m_locked [3];
  int          m_cnt [3];      // samples collected in the current frame
  int          m_buf [3][8];
  logic [31:0] m_dout [3];
  bit          m_valid [3];
  bit          m_err [3];

  task automatic model_update(input int i, input bit r, input bit v, input bit s, input logic [7:0] d);
    int smp;
    longint acc;
    if (r) begin
      m_locked[i] = 0; m_cnt[i] = 0; m_dout[i] = '0; m_valid[i] = 0; m_err[i] = 0;
      return;
    end
    m_valid[i] = 0;
    m_err[i]   = 0;
    if (!v) return;
    smp = int'(d) % (1 << wid[i]);
    if (!m_locked[i]) begin
      if (s) begin
        m_locked[i] = 1;
        m_buf[i][0] = smp;
        m_cnt[i]    = 1;
      end
    end else if (s && m_cnt[i] != 0) begin
      m_err[i]    = 1;
      m_buf[i][0] = smp;
      m_cnt[i]    = 1;
    end else begin
      m_buf[i][m_cnt[i]] = smp;
      m_cnt[i] = m_cnt[i] + 1;
      if (m_cnt[i] == nch[i]) begin
        acc = 0;
        for (int k = 0; k < nch[i]; k++) acc = acc + (longint'(m_buf[i][k]) << (k * wid[i]));
        m_dout[i]  = acc[31:0];
        m_valid[i] = 1;
        m_cnt[i]   = 0;
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic get_act(input int i, output logic [31:0] d, output logic v,
                         output logic [31:0] c, output logic l, output logic e);
    e = 1'b0;
    case (i)
      0: begin d = {30'd0, dout_a}; v = valid_a; c = {31'd0, chan_a}; l = locked_a;
`ifdef FRAME_ERR_EN
         e = err_a;
`endif
      end
      1: begin d = dout_b; v = valid_b; c = {30'd0, chan_b}; l = locked_b;
`ifdef FRAME_ERR_EN
         e = err_b;
`endif
      end
      default: begin d = {20'd0, dout_c}; v = valid_c; c = {30'd0, chan_c}; l = locked_c;
`ifdef FRAME_ERR_EN
         e = err_c;
`endif
      end
    endcase
  endtask

  task automatic check_model();
    logic [31:0] d, c;
    logic v, l, e;
    for (int i = 0; i < 3; i++) begin
      get_act(i, d, v, c, l, e);
      chk($sformatf("model[%0d].dout", i), d, m_dout[i]);
      chk($sformatf("model[%0d].valid", i), {31'd0, v}, {31'd0, m_valid[i]});
      chk($sformatf("model[%0d].chan", i), c, m_locked[i] ? m_cnt[i] : 0);
      chk($sformatf("model[%0d].locked", i), {31'd0, l}, {31'd0, m_locked[i]});
`ifdef FRAME_ERR_EN
      chk($sformatf("model[%0d].frame_err", i), {31'd0, e}, {31'd0, m_err[i]});
`endif
    end
  endtask

  // Drive one cycle of inputs, advance the model on the edge, compare 1 time unit later.
  task automatic step(input bit r, input bit v, input bit s, input logic [7:0] d);
    rst = r; din_valid = v; frame_sync = s; din = d;
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_update(i, r, v, s, d);
    #1;
    check_model();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    int          dut;
    bit          r, v, s;
    logic [7:0]  d;
    bit          ev;   // expected dout_valid
    logic [31:0] ed;   // expected dout
    bit          el;   // expected locked
    bit          ee;   // expected frame_err
  } vec_t;

  vec_t tbl[$];

  task automatic add(input int dut, input bit r, input bit v, input bit s, input logic [7:0] d,
                     input bit ev, input logic [31:0] ed, input bit el, input bit ee);
    vec_t x;
    x.dut = dut; x.r = r; x.v = v; x.s = s; x.d = d;
    x.ev = ev; x.ed = ed; x.el = el; x.ee = ee;
    tbl.push_back(x);
  endtask

  initial begin
    logic [31:0] d, c;
    logic v, l, e;

    for (int i = 0; i < 3; i++) model_update(i, 1'b1, 1'b0, 1'b0, 8'h00);

    // Basic CH_N=2: (sync)1,0,(sync)0,1
    add(0, 1, 0, 0, 8'h00, 0, 32'h0, 0, 0);
    add(0, 0, 1, 1, 8'h01, 0, 32'h0, 1, 0);
    add(0, 0, 1, 0, 8'h00, 1, 32'h1, 1, 0);
    add(0, 0, 1, 1, 8'h00, 0, 32'h1, 1, 0);
    add(0, 0, 1, 0, 8'h01, 1, 32'h2, 1, 0);
    // HUNT discard CH_N=4
    add(1, 1, 0, 0, 8'h00, 0, 32'h0, 0, 0);
    add(1, 0, 1, 0, 8'h11, 0, 32'h0, 0, 0);
    add(1, 0, 1, 0, 8'h22, 0, 32'h0, 0, 0);
    add(1, 0, 1, 1, 8'hA0, 0, 32'h0, 1, 0);
    add(1, 0, 1, 0, 8'hA1, 0, 32'h0, 1, 0);
    add(1, 0, 1, 0, 8'hA2, 0, 32'h0, 1, 0);
    add(1, 0, 1, 0, 8'hA3, 1, 32'hA3A2A1A0, 1, 0);
    // Premature sync CH_N=4
    add(1, 1, 0, 0, 8'h00, 0, 32'h0, 0, 0);
    add(1, 0, 1, 1, 8'h01, 0, 32'h0, 1, 0);
    add(1, 0, 1, 0, 8'h02, 0, 32'h0, 1, 0);
    add(1, 0, 1, 1, 8'h10, 0, 32'h0, 1, 1);
    add(1, 0, 1, 0, 8'h11, 0, 32'h0, 1, 0);
    add(1, 0, 1, 0, 8'h12, 0, 32'h0, 1, 0);
    add(1, 0, 1, 0, 8'h13, 1, 32'h13121110, 1, 0);
    // Wrap/continuity CH_N=3 DATA_W=4
    add(2, 1, 0, 0, 8'h00, 0, 32'h0, 0, 0);
    add(2, 0, 1, 1, 8'h00, 0, 32'h0, 1, 0);
    add(2, 0, 1, 0, 8'h01, 0, 32'h0, 1, 0);
    add(2, 0, 1, 0, 8'h02, 1, 32'h210, 1, 0);
    add(2, 0, 1, 0, 8'h03, 0, 32'h210, 1, 0);
    add(2, 0, 1, 0, 8'h04, 0, 32'h210, 1, 0);
    add(2, 0, 1, 0, 8'h05, 1, 32'h543, 1, 0);
    add(2, 0, 1, 0, 8'h06, 0, 32'h543, 1, 0);
    add(2, 0, 1, 0, 8'h07, 0, 32'h543, 1, 0);
    add(2, 0, 1, 0, 8'h08, 1, 32'h876, 1, 0);

    // Reset held 3 clocks with random inputs: every instance must read all zero.
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'($urandom), 1'($urandom), 8'($urandom));
      for (int i = 0; i < 3; i++) begin
        get_act(i, d, v, c, l, e);
        chk($sformatf("reset[%0d].dout", i), d, 32'h0);
        chk($sformatf("reset[%0d].valid", i), {31'd0, v}, 32'h0);
        chk($sformatf("reset[%0d].chan", i), c, 32'h0);
        chk($sformatf("reset[%0d].locked", i), {31'd0, l}, 32'h0);
      end
    end

    // Directed table.
    for (int n = 0; n < tbl.size(); n++) begin
      step(tbl[n].r, tbl[n].v, tbl[n].s, tbl[n].d);
      get_act(tbl[n].dut, d, v, c, l, e);
      chk($sformatf("tbl[%0d].valid", n), {31'd0, v}, {31'd0, tbl[n].ev});
      chk($sformatf("tbl[%0d].dout", n), d, tbl[n].ed);
      chk($sformatf("tbl[%0d].locked", n), {31'd0, l}, {31'd0, tbl[n].el});
`ifdef FRAME_ERR_EN
      chk($sformatf("tbl[%0d].frame_err", n), {31'd0, e}, {31'd0, tbl[n].ee});
`endif
    end

    // Gaps inside a frame, CH_N=2: (sync)1, three idle clocks, 0.
    step(1'b1, 1'b0, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b1, 8'h01);
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b0, 1'($urandom), 8'($urandom));
      chk("gap.valid_idle", {31'd0, valid_a}, 32'h0);
      chk("gap.chan_idle", {31'd0, chan_a}, 32'h1);
    end
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("gap.valid", {31'd0, valid_a}, 32'h1);
    chk("gap.dout", {30'd0, dout_a}, 32'h1);
    step(1'b0, 1'b0, 1'b0, 8'h00);
    chk("gap.valid_drop", {31'd0, valid_a}, 32'h0);

    // Reset mid-frame: (sync)1, rst, 0 -> unlocked, no valid, dout cleared.
    step(1'b0, 1'b1, 1'b1, 8'h01);
    step(1'b1, 1'b1, 1'b0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 8'h00);
    chk("rstmid.locked", {31'd0, locked_a}, 32'h0);
    chk("rstmid.valid", {31'd0, valid_a}, 32'h0);
    chk("rstmid.dout", {30'd0, dout_a}, 32'h0);

    // Randomized traffic against the model.
    for (int k = 0; k < 400; k++) begin
      step($urandom_range(0, 59) == 0, $urandom_range(0, 3) != 0,
           $urandom_range(0, 6) == 0, 8'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
